// File: rtl/mem_pkg.sv
// Shared types and decode helpers for the miniRV memory-access stage.
package mem_pkg;

    localparam int MEM_OP_W = 4;

    typedef enum logic [MEM_OP_W-1:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LW   = 4'd3,
        MEM_LBU  = 4'd4,
        MEM_LHU  = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    function automatic logic is_load(input logic [MEM_OP_W-1:0] op);
        return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    endfunction

    function automatic logic is_store(input logic [MEM_OP_W-1:0] op);
        return op inside {MEM_SB, MEM_SH, MEM_SW};
    endfunction

    function automatic logic is_misaligned(input logic [MEM_OP_W-1:0] op,
                                           input logic [1:0]          addr_lo);
        logic mis;
        mis = 1'b0;
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: mis = addr_lo[0];
            MEM_LW, MEM_SW:          mis = |addr_lo;
            default:                 mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_lane.sv
// Byte-lane steering: store byte enables / replicated write data, and load
// lane extraction with sign or zero extension.
module mem_lane_unit
    import mem_pkg::*;
(
    input  logic [MEM_OP_W-1:0] op_i,
    input  logic [1:0]          addr_lo_i,
    input  logic [31:0]         sdata_i,
    input  logic [31:0]         rdata_i,
    output logic [3:0]          be_o,
    output logic [31:0]         wdata_o,
    output logic [31:0]         load_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        be_o     = 4'b0000;
        wdata_o  = sdata_i;
        load_o   = rdata_i;
        case (op_i)
            MEM_LB:  begin be_o = 4'b0001 << addr_lo_i; load_o = {{24{byte_sel[7]}}, byte_sel}; end
            MEM_LBU: begin be_o = 4'b0001 << addr_lo_i; load_o = {24'd0, byte_sel}; end
            MEM_LH:  begin be_o = 4'b0011 << {addr_lo_i[1], 1'b0}; load_o = {{16{half_sel[15]}}, half_sel}; end
            MEM_LHU: begin be_o = 4'b0011 << {addr_lo_i[1], 1'b0}; load_o = {16'd0, half_sel}; end
            MEM_LW:  be_o = 4'b1111;
            MEM_SB:  begin be_o = 4'b0001 << addr_lo_i; wdata_o = {4{sdata_i[7:0]}}; end
            MEM_SH:  begin be_o = 4'b0011 << {addr_lo_i[1], 1'b0}; wdata_o = {2{sdata_i[15:0]}}; end
            MEM_SW:  be_o = 4'b1111;
            default: be_o = 4'b0000;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// miniRV MEM stage: drives the req/ack data bus for loads/stores, stalls the
// pipeline while an access is in flight and feeds the MEM/WB register.
module mem_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                cpu_clk,
    input  logic                cpu_rst,
    input  logic                valid_MEM_in,
    input  logic [MEM_OP_W-1:0] mem_op_MEM_in,
    input  logic [31:0]         addr_MEM_in,
    input  logic [31:0]         sdata_MEM_in,
    input  logic [4:0]          wR_MEM_in,
    input  logic                rf_we_MEM_in,
    input  logic [31:0]         wD_MEM_in,
    output logic                bus_req,
    output logic                bus_we,
    output logic [31:0]         bus_addr,
    output logic [31:0]         bus_wdata,
    output logic [3:0]          bus_be,
    input  logic                bus_ack,
    input  logic [31:0]         bus_rdata,
    output logic                stall_MEM,
    output logic [4:0]          wR_MEM_out,
    output logic                rf_we_MEM_out,
    output logic [31:0]         wD_MEM_out,
    output logic                mem_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    mem_state_e  state_q, state_d;
    logic        err_q, err_d;
    logic        bus_req_q, bus_we_q, timed_out_q;
    logic [31:0] bus_addr_q, bus_wdata_q, result_q;
    logic [3:0]  bus_be_q;
    logic [CNT_W-1:0] cnt_q;

    logic        op_is_load, op_is_store, op_is_mem;
    logic        start_acc, misal_acc, timeout_hit;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, lane_load;

    mem_lane_unit u_lane (
        .op_i      (mem_op_MEM_in),
        .addr_lo_i (addr_MEM_in[1:0]),
        .sdata_i   (sdata_MEM_in),
        .rdata_i   (bus_rdata),
        .be_o      (lane_be),
        .wdata_o   (lane_wdata),
        .load_o    (lane_load)
    );

    assign op_is_load  = is_load(mem_op_MEM_in);
    assign op_is_store = is_store(mem_op_MEM_in);
    assign op_is_mem   = op_is_load | op_is_store;
    assign misal_acc   = (state_q == ST_IDLE) && valid_MEM_in && op_is_mem &&
                         is_misaligned(mem_op_MEM_in, addr_MEM_in[1:0]);
    assign start_acc   = (state_q == ST_IDLE) && valid_MEM_in && op_is_mem && !misal_acc;
    assign timeout_hit = (state_q == ST_BUSY) && !bus_ack &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d       = state_q;
        err_d         = 1'b0;
        stall_MEM     = 1'b0;
        wR_MEM_out    = wR_MEM_in;
        rf_we_MEM_out = 1'b0;
        wD_MEM_out    = wD_MEM_in;
        case (state_q)
            ST_IDLE: begin
                rf_we_MEM_out = valid_MEM_in & rf_we_MEM_in & ~op_is_mem;
                stall_MEM     = start_acc;
                err_d         = misal_acc;
                if (start_acc) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                stall_MEM = 1'b1;
                err_d     = timeout_hit;
                if (bus_ack || timeout_hit) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (op_is_load) begin
                    wD_MEM_out    = result_q;
                    rf_we_MEM_out = rf_we_MEM_in & ~timed_out_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q     <= ST_IDLE;
            err_q       <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            timed_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            case (state_q)
                ST_IDLE: if (start_acc) begin
                    bus_req_q   <= 1'b1;
                    bus_we_q    <= op_is_store;
                    bus_addr_q  <= {addr_MEM_in[31:2], 2'b00};
                    bus_be_q    <= lane_be;
                    bus_wdata_q <= lane_wdata;
                    cnt_q       <= '0;
                    timed_out_q <= 1'b0;
                end
                ST_BUSY: begin
                    // Upstream holds op/addr stable while stalled, so lane_load is valid here.
                    if (bus_ack) begin
                        bus_req_q <= 1'b0;
                        result_q  <= lane_load;
                    end else if (timeout_hit) begin
                        bus_req_q   <= 1'b0;
                        result_q    <= '0;
                        timed_out_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_be    = bus_be_q;
    assign mem_err   = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: scoreboarded loads/stores, misalignment,
// bus timeout and reset during an access.
module tb_mem_stage;
    import mem_pkg::*;

    localparam int TO = 4;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic        valid_in;
    logic [3:0]  op_in;
    logic [31:0] addr_in, sdata_in, wd_in;
    logic [4:0]  wr_in;
    logic        rfwe_in;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        stall_MEM, rf_we_MEM_out, mem_err;
    logic [4:0]  wR_MEM_out;
    logic [31:0] wD_MEM_out;

    typedef struct {
        logic [4:0]  wr;
        logic        we;
        logic [31:0] wd;
        logic        chk_wd;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .cpu_clk       (cpu_clk),
        .cpu_rst       (cpu_rst),
        .valid_MEM_in  (valid_in),
        .mem_op_MEM_in (op_in),
        .addr_MEM_in   (addr_in),
        .sdata_MEM_in  (sdata_in),
        .wR_MEM_in     (wr_in),
        .rf_we_MEM_in  (rfwe_in),
        .wD_MEM_in     (wd_in),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_be        (bus_be),
        .bus_ack       (bus_ack),
        .bus_rdata     (bus_rdata),
        .stall_MEM     (stall_MEM),
        .wR_MEM_out    (wR_MEM_out),
        .rf_we_MEM_out (rf_we_MEM_out),
        .wD_MEM_out    (wD_MEM_out),
        .mem_err       (mem_err)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    // wait_n < 0 means the bus never acknowledges.
    task automatic do_mem(input string name, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] rdata, input int wait_n,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input int exp_stall, input exp_t e);
        int   stalls, k, exp_req;
        logic done, we_leak, saw_req, store;
        exp_t got;
        store = op inside {MEM_SB, MEM_SH, MEM_SW};
        sb_q.push_back(e);
        valid_in = 1'b1; op_in = op; addr_in = addr; sdata_in = sdata;
        wr_in = e.wr; rfwe_in = 1'b1; wd_in = 32'h5555_5555; bus_rdata = rdata;
        #1;
        stalls  = stall_MEM ? 1 : 0;
        we_leak = rf_we_MEM_out;
        saw_req = bus_req;
        k = 0; done = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            tick();
            if (bus_req) begin
                saw_req = 1'b1;
                if (k == 0) begin
                    check($sformatf("%s_we", name), {31'd0, bus_we}, {31'd0, store});
                    check($sformatf("%s_addr", name), bus_addr, {addr[31:2], 2'b00});
                    check($sformatf("%s_be", name), {28'd0, bus_be}, {28'd0, exp_be});
                    if (store) check($sformatf("%s_wdata", name), bus_wdata, exp_wdata);
                end
                bus_ack = (k == wait_n);
                k++;
            end else begin
                bus_ack = 1'b0;
            end
            if (stall_MEM) begin
                stalls++;
                we_leak = we_leak | rf_we_MEM_out;
            end else if (!bus_req) begin
                done = 1'b1;
                got  = sb_q.pop_front();
                check($sformatf("%s_wr", name), {27'd0, wR_MEM_out}, {27'd0, got.wr});
                check($sformatf("%s_rfwe", name), {31'd0, rf_we_MEM_out}, {31'd0, got.we});
                if (got.chk_wd) check($sformatf("%s_wd", name), wD_MEM_out, got.wd);
                check($sformatf("%s_err", name), {31'd0, mem_err}, {31'd0, got.err});
            end
        end
        if (!done) check($sformatf("%s_wait_budget", name), 32'd0, 32'd1);
        exp_req = (exp_stall == 0) ? 0 : ((wait_n < 0) ? TO : wait_n + 1);
        check($sformatf("%s_stalls", name), stalls, exp_stall);
        check($sformatf("%s_reqcyc", name), k, exp_req);
        check($sformatf("%s_req_seen", name), {31'd0, saw_req}, {31'd0, exp_stall > 0});
        check($sformatf("%s_rfwe_stall", name), {31'd0, we_leak}, 32'd0);
        bus_ack = 1'b0; valid_in = 1'b0; op_in = MEM_NONE; rfwe_in = 1'b0;
        tick();
        check($sformatf("%s_err_clear", name), {31'd0, mem_err}, 32'd0);
        check($sformatf("%s_idle_stall", name), {31'd0, stall_MEM}, 32'd0);
    endtask

    function automatic exp_t mk(input logic [4:0] wr, input logic we, input logic [31:0] wd,
                                input logic chk_wd, input logic err);
        exp_t e;
        e.wr = wr; e.we = we; e.wd = wd; e.chk_wd = chk_wd; e.err = err;
        return e;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cpu_rst = 1'b1; valid_in = 1'b0; op_in = MEM_NONE; addr_in = '0; sdata_in = '0;
        wd_in = '0; wr_in = '0; rfwe_in = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
        tick(); tick();
        cpu_rst = 1'b0;
        #1;
        check("rst_req",   {31'd0, bus_req},   32'd0);
        check("rst_we",    {31'd0, bus_we},    32'd0);
        check("rst_addr",  bus_addr,           32'd0);
        check("rst_wdata", bus_wdata,          32'd0);
        check("rst_be",    {28'd0, bus_be},    32'd0);
        check("rst_stall", {31'd0, stall_MEM}, 32'd0);
        check("rst_err",   {31'd0, mem_err},   32'd0);

        // Non-memory pass-through, including an undefined op code.
        valid_in = 1'b1; op_in = MEM_NONE; wr_in = 5'd9; rfwe_in = 1'b1; wd_in = 32'h0BAD_F00D;
        #1;
        check("pt_rfwe",  {31'd0, rf_we_MEM_out}, 32'd1);
        check("pt_wd",    wD_MEM_out,             32'h0BAD_F00D);
        check("pt_wr",    {27'd0, wR_MEM_out},    32'd9);
        op_in = 4'hF;
        #1;
        check("undef_stall", {31'd0, stall_MEM},     32'd0);
        check("undef_rfwe",  {31'd0, rf_we_MEM_out}, 32'd1);
        valid_in = 1'b0;
        #1;
        check("inval_rfwe", {31'd0, rf_we_MEM_out}, 32'd0);
        tick();
        check("undef_noreq", {31'd0, bus_req}, 32'd0);

        do_mem("lw",    MEM_LW,  32'h0000_1008, 32'h0, 32'hDEAD_BEEF, 0, 4'b1111, 32'h0, 2,
               mk(5'd1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0));
        do_mem("lb3",   MEM_LB,  32'h0000_1003, 32'h0, 32'h80FF_7F01, 0, 4'b1000, 32'h0, 2,
               mk(5'd2, 1'b1, 32'hFFFF_FF80, 1'b1, 1'b0));
        do_mem("lbu3",  MEM_LBU, 32'h0000_1003, 32'h0, 32'h80FF_7F01, 0, 4'b1000, 32'h0, 2,
               mk(5'd3, 1'b1, 32'h0000_0080, 1'b1, 1'b0));
        do_mem("lb1",   MEM_LB,  32'h0000_1001, 32'h0, 32'h80FF_7F01, 0, 4'b0010, 32'h0, 2,
               mk(5'd4, 1'b1, 32'h0000_007F, 1'b1, 1'b0));
        do_mem("lh2",   MEM_LH,  32'h0000_1002, 32'h0, 32'h80FF_7F01, 0, 4'b1100, 32'h0, 2,
               mk(5'd5, 1'b1, 32'hFFFF_80FF, 1'b1, 1'b0));
        do_mem("lhu0",  MEM_LHU, 32'h0000_1000, 32'h0, 32'h80FF_7F01, 1, 4'b0011, 32'h0, 3,
               mk(5'd6, 1'b1, 32'h0000_7F01, 1'b1, 1'b0));
        do_mem("sh",    MEM_SH,  32'h0000_2002, 32'h1234_ABCD, 32'h0, 3, 4'b1100, 32'hABCD_ABCD, 5,
               mk(5'd7, 1'b0, 32'h0, 1'b0, 1'b0));
        do_mem("sb",    MEM_SB,  32'h0000_3001, 32'h0000_00A5, 32'h0, 0, 4'b0010, 32'hA5A5_A5A5, 2,
               mk(5'd8, 1'b0, 32'h0, 1'b0, 1'b0));
        do_mem("sw",    MEM_SW,  32'h0000_4000, 32'hCAFE_BABE, 32'h0, 0, 4'b1111, 32'hCAFE_BABE, 2,
               mk(5'd9, 1'b0, 32'h0, 1'b0, 1'b0));
        do_mem("lw_mis",  MEM_LW,  32'h0000_1001, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 0,
               mk(5'd10, 1'b0, 32'h0, 1'b0, 1'b1));
        do_mem("sh_mis",  MEM_SH,  32'h0000_2003, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 0,
               mk(5'd11, 1'b0, 32'h0, 1'b0, 1'b1));
        do_mem("lw_half", MEM_LW,  32'h0000_1002, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 0,
               mk(5'd12, 1'b0, 32'h0, 1'b0, 1'b1));
        do_mem("lw_to",   MEM_LW,  32'h0000_5000, 32'h0, 32'h1234_5678, -1, 4'b1111, 32'h0, 1 + TO,
               mk(5'd13, 1'b0, 32'h0, 1'b1, 1'b1));

        // Reset while BUSY abandons the access; a late ack must not write back.
        valid_in = 1'b1; op_in = MEM_LW; addr_in = 32'h0000_1008; wr_in = 5'd14; rfwe_in = 1'b1;
        tick();
        check("rstb_busy", {31'd0, bus_req}, 32'd1);
        cpu_rst = 1'b1; op_in = MEM_NONE; wd_in = 32'h1111_1111;
        tick();
        check("rstb_req",   {31'd0, bus_req},   32'd0);
        check("rstb_stall", {31'd0, stall_MEM}, 32'd0);
        check("rstb_be",    {28'd0, bus_be},    32'd0);
        cpu_rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
        tick();
        bus_ack = 1'b0;
        #1;
        check("late_ack_stall", {31'd0, stall_MEM},     32'd0);
        check("late_ack_rfwe",  {31'd0, rf_we_MEM_out}, 32'd1);
        check("late_ack_wd",    wD_MEM_out,             32'h1111_1111);
        check("late_ack_err",   {31'd0, mem_err},       32'd0);
        check("late_ack_req",   {31'd0, bus_req},       32'd0);
        tick();
        check("post_late_rfwe", {31'd0, rf_we_MEM_out}, 32'd1);
        check("post_late_wd",   wD_MEM_out,             32'h1111_1111);
        check("sb_empty",       sb_q.size(),            32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
